// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : uart_pkg
//  Description : Definitions shared by the UART receiver and transmitter.
//                Holds the frame state encoding, the oversampling factor,
//                the half-bit factor and the prescale sanitising helper.
//  Revision    : 1.0  initial release
// ============================================================================
package uart_pkg;

   // clk cycles per bit = prescale * OVERSAMPLE
   localparam int OVERSAMPLE = 8;
   // Distance from the start edge to mid start bit, in units of prescale
   localparam int HALF_BIT   = 4;

   // Shift amounts equivalent to the two factors above (both are powers of two)
   localparam int OVS_SHIFT  = $clog2(OVERSAMPLE);
   localparam int HALF_SHIFT = $clog2(HALF_BIT);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } uart_state_e;

   // A prescale of zero would give a zero-length bit; run it as 1 instead.
   function automatic logic [15:0] eff_prescale(input logic [15:0] p);
      return (p == 16'd0) ? 16'd1 : p;
   endfunction

endpackage
`default_nettype wire

// File: rtl/uart_sync2.sv
`default_nettype none
// ============================================================================
//  Module      : uart_sync2
//  Description : Two-flop synchroniser for an asynchronous serial line.
//                Both flops reset to 1, matching the idle level of the line,
//                so no spurious start bit is seen when reset is released.
//  Ports       : clk  - clock
//                rst  - asynchronous active-high reset
//                d_i  - asynchronous input
//                q_o  - synchronised output (two clk cycles of latency)
//  Revision    : 1.0  initial release
// ============================================================================
module uart_sync2 (
   input  logic clk,
   input  logic rst,
   input  logic d_i,
   output logic q_o
);

   logic [1:0] sync_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync_q <= 2'b11;
      end else begin
         sync_q <= {sync_q[0], d_i};
      end
   end

   assign q_o = sync_q[1];

endmodule
`default_nettype wire

// File: rtl/uart_rx.sv
`default_nettype none
// ============================================================================
//  Module      : uart_rx
//  Description : UART receiver, 8x oversampled, with an AXI-Stream style
//                single-entry output. Detects the start edge, samples every
//                bit at its centre, checks the stop bit and reports frame
//                and overrun errors as one-cycle pulses.
//  Ports       : clk           - clock (rising edge)
//                rst           - asynchronous active-high reset
//                rxd           - serial line, asynchronous, idle high
//                prescale      - bit period = prescale*8 clk cycles
//                m_axis_tdata  - received word
//                m_axis_tvalid - tdata holds an unconsumed word
//                m_axis_tready - downstream accepts the word
//                busy          - frame reception in progress
//                frame_error   - pulse: stop bit sampled low
//                overrun_error - pulse: word completed while tvalid was high
//  Revision    : 1.0  initial release
// ============================================================================
module uart_rx
   import uart_pkg::*;
#(
   parameter int DATA_WIDTH = 8   // must be at least 2
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  rxd,
   input  logic [15:0]           prescale,
   output logic [DATA_WIDTH-1:0] m_axis_tdata,
   output logic                  m_axis_tvalid,
   input  logic                  m_axis_tready,
   output logic                  busy,
   output logic                  frame_error,
   output logic                  overrun_error
);

   // Wide enough for prescale*OVERSAMPLE-1 with 16-bit prescale, so no wrap.
   localparam int CNT_W     = 16 + OVS_SHIFT;
   localparam int BIT_CNT_W = $clog2(DATA_WIDTH);

   logic                  rxd_s;
   uart_state_e           state_q;
   logic [CNT_W-1:0]      cnt_q;
   logic [15:0]           presc_q;
   logic [BIT_CNT_W-1:0]  bit_cnt_q;
   logic [DATA_WIDTH-1:0] shift_q;
   logic                  armed_q;
   logic [DATA_WIDTH-1:0] tdata_q;
   logic                  tvalid_q;
   logic                  busy_q;
   logic                  fe_q;
   logic                  ov_q;

   logic [15:0]           presc_in_d;
   logic [CNT_W-1:0]      start_reload_d;
   logic [CNT_W-1:0]      bit_reload_d;
   logic                  handshake_d;

   uart_sync2 u_sync (
      .clk (clk),
      .rst (rst),
      .d_i (rxd),
      .q_o (rxd_s)
   );

   // The start-edge load uses the live prescale; every later reload uses the
   // value latched at the start edge so mid-frame changes have no effect.
   assign presc_in_d     = eff_prescale(prescale);
   assign start_reload_d = (CNT_W'(presc_in_d) << HALF_SHIFT) - CNT_W'(1);
   assign bit_reload_d   = (CNT_W'(presc_q) << OVS_SHIFT) - CNT_W'(1);
   assign handshake_d    = tvalid_q && m_axis_tready;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         presc_q   <= 16'd1;
         bit_cnt_q <= '0;
         shift_q   <= '0;
         armed_q   <= 1'b1;
         tdata_q   <= '0;
         tvalid_q  <= 1'b0;
         busy_q    <= 1'b0;
         fe_q      <= 1'b0;
         ov_q      <= 1'b0;
      end else begin
         fe_q <= 1'b0;
         ov_q <= 1'b0;

         // A completing frame below overrides this clear.
         if (handshake_d) begin
            tvalid_q <= 1'b0;
         end

         case (state_q)
            IDLE: begin
               // armed_q is cleared by a frame error so a held-low break
               // line cannot retrigger; it needs to see the line high first.
               if (rxd_s) begin
                  armed_q <= 1'b1;
               end else if (armed_q) begin
                  presc_q <= presc_in_d;
                  cnt_q   <= start_reload_d;
                  busy_q  <= 1'b1;
                  state_q <= START;
               end
            end

            START: begin
               if (cnt_q != '0) begin
                  cnt_q <= cnt_q - CNT_W'(1);
               end else if (rxd_s) begin
                  // Line back high at mid start bit: glitch, not a frame.
                  busy_q  <= 1'b0;
                  state_q <= IDLE;
               end else begin
                  cnt_q     <= bit_reload_d;
                  bit_cnt_q <= '0;
                  state_q   <= DATA;
               end
            end

            DATA: begin
               if (cnt_q != '0) begin
                  cnt_q <= cnt_q - CNT_W'(1);
               end else begin
                  // LSB first: the first bit ends up in bit 0 after all shifts.
                  shift_q <= {rxd_s, shift_q[DATA_WIDTH-1:1]};
                  cnt_q   <= bit_reload_d;
                  if (bit_cnt_q == BIT_CNT_W'(DATA_WIDTH - 1)) begin
                     state_q <= STOP;
                  end else begin
                     bit_cnt_q <= bit_cnt_q + BIT_CNT_W'(1);
                  end
               end
            end

            STOP: begin
               if (cnt_q != '0) begin
                  cnt_q <= cnt_q - CNT_W'(1);
               end else begin
                  busy_q  <= 1'b0;
                  state_q <= IDLE;
                  if (rxd_s) begin
                     tdata_q  <= shift_q;
                     tvalid_q <= 1'b1;
                     // A word taken in this same cycle is consumed, not lost.
                     ov_q     <= tvalid_q && !m_axis_tready;
                  end else begin
                     fe_q    <= 1'b1;
                     armed_q <= 1'b0;
                  end
               end
            end

            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign m_axis_tdata  = tdata_q;
   assign m_axis_tvalid = tvalid_q;
   assign busy          = busy_q;
   assign frame_error   = fe_q;
   assign overrun_error = ov_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uart_rx
//  Description : Self-checking bench for uart_rx. A table of single frames
//                is driven onto rxd and the accepted words and error pulses
//                are compared against hand-computed values, followed by
//                hand-written sequences for latency, back-to-back frames,
//                overrun, break handling, false start and mid-frame reset.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_uart_rx;

   logic        clk = 1'b0;
   logic        rst;
   logic        rxd;
   logic [15:0] prescale;
   logic [7:0]  tdata;
   logic        tvalid;
   logic        tready;
   logic        busy;
   logic        fe;
   logic        ov;

   always #5 clk = ~clk;

   uart_rx #(.DATA_WIDTH(8)) dut (
      .clk           (clk),
      .rst           (rst),
      .rxd           (rxd),
      .prescale      (prescale),
      .m_axis_tdata  (tdata),
      .m_axis_tvalid (tvalid),
      .m_axis_tready (tready),
      .busy          (busy),
      .frame_error   (fe),
      .overrun_error (ov)
   );

   int n_vec = 0;
   int n_err = 0;

   // ---------------- cycle counter and output monitor ----------------
   int         cyc = 0;
   logic [7:0] rx_q[$];
   int         fe_cnt     = 0;
   int         ov_cnt     = 0;
   int         busy_rises = 0;
   int         rise_cyc   = 0;
   logic       tv_prev    = 1'b0;
   logic       busy_prev  = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   // Inputs change just after the rising edge, so values seen here are the
   // ones the DUT samples on the next rising edge.
   always @(negedge clk) begin
      if (!rst) begin
         if (tvalid && tready) rx_q.push_back(tdata);
         if (fe) fe_cnt <= fe_cnt + 1;
         if (ov) ov_cnt <= ov_cnt + 1;
         if (busy && !busy_prev) busy_rises <= busy_rises + 1;
         if (tvalid && !tv_prev) rise_cyc <= cyc;
      end
      tv_prev   <= tvalid;
      busy_prev <= busy;
   end

   initial begin
      #3_000_000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   // ---------------- helpers ----------------
   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_cycles(input int n);
      repeat (n) tick();
   endtask

   function automatic int bit_time(input logic [15:0] p);
      return ((p == 16'd0) ? 1 : int'(p)) * 8;
   endfunction

   function automatic logic [7:0] last_rx();
      if (rx_q.size() == 0) return 8'hxx;
      return rx_q[rx_q.size() - 1];
   endfunction

   int start_cyc = 0;

   // Drives start bit, 8 data bits LSB first and the given stop level,
   // then leaves the line at end_lvl.
   task automatic send(input logic [7:0] d, input logic stop, input logic end_lvl);
      logic [9:0] frame;
      int         bt;
      frame = {stop, d, 1'b0};
      bt    = bit_time(prescale);
      start_cyc = cyc;
      for (int i = 0; i < 10; i++) begin
         rxd = frame[i];
         wait_cycles(bt);
      end
      rxd = end_lvl;
   endtask

   // ---------------- vector table ----------------
   typedef struct {
      logic [7:0]  data;
      logic        stop;
      logic [15:0] presc;
      int          exp_hs;
      int          exp_fe;
   } vec_t;

   vec_t vecs[8];

   int hs0, fe0, ov0, br0, lat;

   initial begin
      vecs[0] = '{8'h2D, 1'b1, 16'd6, 1, 0};
      vecs[1] = '{8'h55, 1'b1, 16'd6, 1, 0};
      vecs[2] = '{8'hA3, 1'b1, 16'd6, 1, 0};
      vecs[3] = '{8'h00, 1'b1, 16'd6, 1, 0};
      vecs[4] = '{8'hFF, 1'b1, 16'd6, 1, 0};
      vecs[5] = '{8'h81, 1'b1, 16'd1, 1, 0};
      vecs[6] = '{8'h7E, 1'b1, 16'd0, 1, 0};  // prescale 0 runs as 1
      vecs[7] = '{8'h96, 1'b0, 16'd6, 0, 1};  // bad stop bit

      rst      = 1'b1;
      rxd      = 1'b1;
      tready   = 1'b0;
      prescale = 16'd6;
      wait_cycles(5);

      // ---- reset state ----
      check("reset_tvalid", {31'd0, tvalid}, 32'd0);
      check("reset_tdata",  {24'd0, tdata},  32'd0);
      check("reset_busy",   {31'd0, busy},   32'd0);
      check("reset_fe",     {31'd0, fe},     32'd0);
      check("reset_ov",     {31'd0, ov},     32'd0);
      rst = 1'b0;
      wait_cycles(10);

      // ---- table: single frames, sink always ready ----
      tready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         prescale = vecs[i].presc;
         hs0 = rx_q.size();
         fe0 = fe_cnt;
         ov0 = ov_cnt;
         send(vecs[i].data, vecs[i].stop, 1'b1);
         wait_cycles(2 * bit_time(vecs[i].presc));
         check($sformatf("vec%0d_handshakes", i), rx_q.size() - hs0, vecs[i].exp_hs);
         check($sformatf("vec%0d_frame_err", i), fe_cnt - fe0, vecs[i].exp_fe);
         check($sformatf("vec%0d_overrun", i), ov_cnt - ov0, 0);
         if (vecs[i].exp_hs != 0)
            check($sformatf("vec%0d_data", i), {24'd0, last_rx()}, {24'd0, vecs[i].data});
      end

      // ---- 0x2D latency, hold while not ready, then handshake ----
      prescale = 16'd6;
      tready   = 1'b0;
      hs0      = rx_q.size();
      send(8'h2D, 1'b1, 1'b1);
      wait_cycles(10);
      lat = rise_cyc - start_cyc;
      check("lat_tvalid", {31'd0, tvalid}, 32'd1);
      check("lat_tdata", {24'd0, tdata}, 32'h2D);
      check("lat_window", {31'd0, (lat >= 440 && lat <= 500)}, 32'd1);
      wait_cycles(100);
      check("hold_tdata", {24'd0, tdata}, 32'h2D);
      check("hold_tvalid", {31'd0, tvalid}, 32'd1);
      tready = 1'b1;
      tick();
      tready = 1'b0;
      check("hs_clear_tvalid", {31'd0, tvalid}, 32'd0);
      check("hs_count", rx_q.size() - hs0, 1);
      check("hs_data", {24'd0, last_rx()}, 32'h2D);

      // ---- back-to-back 0x55, 0xA3 ----
      tready = 1'b1;
      hs0 = rx_q.size();
      fe0 = fe_cnt;
      ov0 = ov_cnt;
      send(8'h55, 1'b1, 1'b1);
      send(8'hA3, 1'b1, 1'b1);
      wait_cycles(96);
      check("b2b_count", rx_q.size() - hs0, 2);
      check("b2b_first", {24'd0, (rx_q.size() >= 2) ? rx_q[rx_q.size() - 2] : 8'hxx}, 32'h55);
      check("b2b_second", {24'd0, last_rx()}, 32'hA3);
      check("b2b_errors", (fe_cnt - fe0) + (ov_cnt - ov0), 0);

      // ---- overrun: 0x11 then 0x22 with sink stalled ----
      tready = 1'b0;
      hs0 = rx_q.size();
      ov0 = ov_cnt;
      send(8'h11, 1'b1, 1'b1);
      send(8'h22, 1'b1, 1'b1);
      wait_cycles(96);
      check("ovr_pulses", ov_cnt - ov0, 1);
      check("ovr_tdata", {24'd0, tdata}, 32'h22);
      check("ovr_tvalid", {31'd0, tvalid}, 32'd1);
      tready = 1'b1;
      tick();
      check("ovr_drain_count", rx_q.size() - hs0, 1);
      check("ovr_drain_data", {24'd0, last_rx()}, 32'h22);

      // ---- frame error followed by a held-low break ----
      hs0 = rx_q.size();
      fe0 = fe_cnt;
      br0 = busy_rises;
      send(8'h96, 1'b0, 1'b0);
      wait_cycles(4 * 48);
      check("brk_fe_pulses", fe_cnt - fe0, 1);
      check("brk_busy", {31'd0, busy}, 32'd0);
      check("brk_no_rearm", busy_rises - br0, 1);
      check("brk_tvalid", {31'd0, tvalid}, 32'd0);
      check("brk_no_word", rx_q.size() - hs0, 0);
      rxd = 1'b1;
      wait_cycles(48);
      send(8'h5A, 1'b1, 1'b1);
      wait_cycles(96);
      check("brk_recover_data", {24'd0, last_rx()}, 32'h5A);

      // ---- false start: 10-cycle low pulse ----
      hs0 = rx_q.size();
      fe0 = fe_cnt;
      ov0 = ov_cnt;
      br0 = busy_rises;
      rxd = 1'b0;
      wait_cycles(10);
      rxd = 1'b1;
      wait_cycles(10);
      check("fs_busy_mid", {31'd0, busy}, 32'd1);
      wait_cycles(10);
      check("fs_busy_end", {31'd0, busy}, 32'd0);
      wait_cycles(100);
      check("fs_no_word", rx_q.size() - hs0, 0);
      check("fs_no_err", (fe_cnt - fe0) + (ov_cnt - ov0), 0);
      check("fs_busy_rises", busy_rises - br0, 1);

      // ---- reset during DATA, with a word pending ----
      tready = 1'b0;
      send(8'h3C, 1'b1, 1'b1);
      wait_cycles(20);
      check("rst_pre_tvalid", {31'd0, tvalid}, 32'd1);
      begin
         logic [9:0] fr;
         fr = {1'b1, 8'hC3, 1'b0};
         for (int i = 0; i < 4; i++) begin
            rxd = fr[i];
            wait_cycles(48);
         end
      end
      check("rst_pre_busy", {31'd0, busy}, 32'd1);
      rst = 1'b1;
      tick();
      check("rst_mid_tvalid", {31'd0, tvalid}, 32'd0);
      check("rst_mid_tdata", {24'd0, tdata}, 32'd0);
      check("rst_mid_busy", {31'd0, busy}, 32'd0);
      check("rst_mid_errs", {30'd0, fe, ov}, 32'd0);
      wait_cycles(3);
      rxd = 1'b1;
      wait_cycles(2);
      rst = 1'b0;
      tready = 1'b1;
      wait_cycles(48);
      hs0 = rx_q.size();
      fe0 = fe_cnt;
      ov0 = ov_cnt;
      send(8'hC3, 1'b1, 1'b1);
      wait_cycles(96);
      check("rst_after_count", rx_q.size() - hs0, 1);
      check("rst_after_data", {24'd0, last_rx()}, 32'hC3);
      check("rst_after_errs", (fe_cnt - fe0) + (ov_cnt - ov0), 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, meaning the number of data bits per frame.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all logic is rising-edge clocked.
REQ-003 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-004 SHALL have port rxd, input, 1 bit: serial line, asynchronous to clk; idle high.
REQ-005 SHALL have port prescale, input, 16 bits: bit period = prescale*8 clk cycles.
REQ-006 SHALL have port m_axis_tdata, output, DATA_WIDTH bits: received byte.
REQ-007 SHALL have port m_axis_tvalid, output, 1 bit: tdata holds an unconsumed byte.
REQ-008 SHALL have port m_axis_tready, input, 1 bit: downstream accepts.
REQ-009 SHALL have port busy, output, 1 bit: high from start-bit detect through stop-bit sample.
REQ-010 SHALL have port frame_error, output, 1 bit: one-cycle pulse on bad stop bit.
REQ-011 SHALL have port overrun_error, output, 1 bit: one-cycle pulse when a byte completes while tvalid is still high.

Function
REQ-012 SHALL pass rxd through a 2-flop synchronizer; all decisions use the synchronized value rxd_s.
REQ-013 SHALL implement the states IDLE, START, DATA, STOP.
REQ-014 SHALL, in IDLE, on rxd_s==0: latch prescale (0 treated as 1), load the counter with prescale*4-1, assert busy, and go to START.
REQ-015 SHALL, in START at counter expiry (mid start bit): if rxd_s==1, treat it as a false start, deassert busy and return to IDLE; otherwise go to DATA with the counter at prescale*8-1.
REQ-016 SHALL, in DATA, sample rxd_s at each counter expiry into the shift register LSB-first (first data bit -> tdata[0]); after DATA_WIDTH samples it goes to STOP with the counter reloaded to prescale*8-1.
REQ-017 SHALL, in STOP at counter expiry: if rxd_s==1, load m_axis_tdata and assert m_axis_tvalid on the next cycle; if rxd_s==0, pulse frame_error, leave tdata/tvalid unchanged and discard the byte; in both cases return to IDLE and deassert busy.
REQ-018 SHALL, after a frame error, not re-arm until rxd_s has been seen high (a break does not retrigger).
REQ-019 SHALL clear m_axis_tvalid in the cycle after tvalid&&tready is sampled high; tdata SHALL stay stable while tvalid=1 and tready=0.
REQ-020 SHALL, on a valid stop when tvalid=1 and no handshake occurs that cycle, overwrite tdata, keep tvalid=1 and pulse overrun_error; a simultaneous handshake counts as consumed and is not an overrun.
REQ-021 SHALL ignore prescale changes mid-frame.
REQ-022 SHALL have a total counter width of at least 19 bits (prescale*8) with no wrap.

Reset
REQ-023 SHALL, on rst: state=IDLE, m_axis_tvalid=0, m_axis_tdata=0, busy=0, frame_error=0, overrun_error=0, synchronizer flops=1, counter and shift register=0.
REQ-024 SHALL, on reset mid-frame, abort the frame without output and resume with IDLE detection after release.

Structure
REQ-025 SHALL place the state enum, the OVERSAMPLE=8 constant and the half-bit factor 4 in shared package uart_pkg, reused by the TX.
REQ-026 SHALL contain one sub-module, uart_sync2 (2-flop synchronizer, reset value 1); the FSM, counter and shifter stay in uart_rx.

Verification
REQ-027 SHALL, with DUT TX looped back, prescale=6, send 0x2D and require tdata=0x2D (not 0xB4), with tvalid rising about 10*48 cycles after the start edge.
REQ-028 SHALL, with tready=1, send 0x55 then 0xA3 back-to-back and require two handshakes, in order, with no errors.
REQ-029 SHALL, with tready=0, send 0x11 then 0x22 and require an overrun_error pulse, tdata=0x22 and tvalid=1.
REQ-030 SHALL drive a frame with stop bit=0 and require a frame_error pulse, tvalid=0, and no re-arm until rxd returns high.
REQ-031 SHALL drive rxd low for 10 cycles (prescale=6) and require no byte, no error, and busy back to 0 by cycle ~26.
REQ-032 SHALL assert rst during DATA and require all outputs at reset values, after which a following 0xC3 frame is received correctly.
